ramb4_s2_s4_fifo_ctrl: RTL and testbench
========================================

# ramb4_s2_s4_fifo_ctrl

Single-clock FIFO controller that drives a RAMB4_S2_S4 block RAM as 2-bit-in / 4-bit-out width-converting storage. It owns the write pointer on port A (2-bit, 2048 entries) and the read pointer on port B (4-bit, 1024 entries), and generates occupancy flags. It exposes a push/pop handshake to the surrounding datapath. It sits directly upstream of the RAM, drives every RAM input, and consumes the RAM's DOB.

## Interface
- AFULL_THRESH, 12'd1920: ALMOST_FULL asserts when COUNT >= this value, in 2-bit units.
- AEMPTY_THRESH, 12'd4: ALMOST_EMPTY asserts when COUNT <= this value, in 2-bit units.
- CLK  in  1  single clock for the controller and both RAM ports (drive RAM CLKA/CLKB from the same net).
- RST  in  1  asynchronous, active-high reset.
- WR_EN  in  1  push request for one 2-bit unit.
- DIN  in  2  push data.
- RD_EN  in  1  pop request for one 4-bit word.
- DOUT  out  4  pop data, a direct pass-through of DOB.
- DOUT_VALID  out  1  DOUT holds popped data this cycle.
- FULL  out  1  COUNT == 2048.
- EMPTY  out  1  COUNT < 2, meaning no complete 4-bit word is available.
- ALMOST_FULL, ALMOST_EMPTY  out  1 each  threshold flags.
- COUNT  out  12  occupancy in 2-bit units, range 0..2048.
- OVERFLOW, UNDERFLOW  out  1 each  sticky error flags, cleared only by RST.
- ADDRA out 11, DIA out 2, ENA out 1, WEA out 1, RSTA out 1: RAM port A.
- ADDRB out 10, DIB out 4, ENB out 1, WEB out 1, RSTB out 1: RAM port B.
- DOB  in  4  RAM port B read data.

## Operation
- Packing: a 2-bit unit at port A address a lands in port B word a>>1, bit slice [2*(a&1)+1 : 2*(a&1)]. The first-pushed unit of a word becomes DOUT[1:0]; the second becomes DOUT[3:2].
- Pointers: wr_ptr is 11 bits and rd_ptr is 10 bits. Both wrap naturally modulo 2048 and 1024.
- Outputs to the RAM are combinational from state and requests:
  - ADDRA=wr_ptr, DIA=DIN, ENA=WEA=push_ok.
  - ADDRB=rd_ptr, ENB=pop_ok.
  - WEB=0, DIB=0, RSTA=0, RSTB=0.
- push_ok = WR_EN & ~FULL. pop_ok = RD_EN & ~EMPTY.
- On push_ok, wr_ptr increments by 1.
- On pop_ok, rd_ptr increments by 1 and DOUT_VALID is registered high for the next cycle.
- COUNT update per cycle: COUNT + push_ok − 2*pop_ok, computed at 12 bits. Simultaneous push and pop is allowed; the net change is −1.
- A push while FULL is dropped, leaves state unchanged, and sets OVERFLOW.
- A pop while EMPTY is dropped, leaves state unchanged, and sets UNDERFLOW.
- With COUNT==1, EMPTY stays asserted; the lone unit waits for its partner.
- No port collision is possible. Whenever pop_ok holds (COUNT ≥ 2), the write target wr_ptr>>1 differs from rd_ptr, so no bypass logic is required.
- Flags FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY are decoded from the registered COUNT. None of them depends on same-cycle requests.

## Timing
- Reset values (asynchronous, while RST=1):
  - wr_ptr=0, rd_ptr=0, COUNT=0.
  - EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0.
  - DOUT_VALID=0, OVERFLOW=0, UNDERFLOW=0.
  - ENA=0 and ENB=0 regardless of WR_EN/RD_EN.
- RAM contents are not cleared by RST. Data pushed before reset is lost logically.
- Push latency: data written at edge N is counted in COUNT after edge N. It is poppable after edge N only if it completes a word.
- Pop latency: RD_EN sampled at edge N gives DOUT (from DOB) valid with DOUT_VALID=1 after edge N. It stays valid until the next edge and is not held.
- Back-to-back pops yield one word per cycle.
- Reset asserted mid-pop forces DOUT_VALID low immediately. DOUT is undefined after reset until the next pop.

## Test plan
- Reset then push 2'b01, 2'b10 → COUNT=2, EMPTY=0. Then pop → next cycle DOUT=4'b1001, DOUT_VALID=1, COUNT=0, EMPTY=1.
- Push a single unit then pop → pop ignored, UNDERFLOW=1 and sticky, COUNT=1, ENB never asserted.
- Push 2048 units → FULL=1 at COUNT=2048 and ALMOST_FULL=1 from COUNT=1920. Then a 2049th push → OVERFLOW=1, wr_ptr unchanged at 0.
- Fill to 2048, then drain 1024 pops → words returned in order with correct packing across the pointer wrap. End with COUNT=0, rd_ptr=0.
- At COUNT=3, push and pop in the same cycle → COUNT=2, DOUT_VALID=1 next cycle with the oldest word.
- Assert RST during a streaming push/pop at COUNT=100 → all outputs take reset values asynchronously. Resume pushing 2'b11,2'b00 and popping → DOUT=4'b0011.

Source files
------------

// File: rtl/ramb4_s2_s4_fifo_ctrl.sv
// FIFO controller for a RAMB4_S2_S4 block RAM: 2-bit units pushed on port A,
// 4-bit words popped on port B, with occupancy flags and sticky error flags.
module ramb4_s2_s4_fifo_ctrl #(
   parameter logic [11:0] AFULL_THRESH  = 12'd1920,
   parameter logic [11:0] AEMPTY_THRESH = 12'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [1:0]  din,
   input  logic        rd_en,
   output logic [3:0]  dout,
   output logic        dout_valid,
   output logic        full,
   output logic        empty,
   output logic        almost_full,
   output logic        almost_empty,
   output logic [11:0] count,
   output logic        overflow,
   output logic        underflow,
   output logic [10:0] addra,
   output logic [1:0]  dia,
   output logic        ena,
   output logic        wea,
   output logic        rsta,
   output logic [9:0]  addrb,
   output logic [3:0]  dib,
   output logic        enb,
   output logic        web,
   output logic        rstb,
   input  logic [3:0]  dob
);

   logic [10:0] wr_ptr;
   logic [9:0]  rd_ptr;
   logic        push_ok;
   logic        pop_ok;

   assign full         = (count == 12'd2048);
   assign empty        = (count < 12'd2);
   assign almost_full  = (count >= AFULL_THRESH);
   assign almost_empty = (count <= AEMPTY_THRESH);

   // Gated by rst so the RAM enables stay low while reset is held,
   // even though the flags read as not-full during reset.
   assign push_ok = wr_en & ~full & ~rst;
   assign pop_ok  = rd_en & ~empty & ~rst;

   assign addra = wr_ptr;
   assign dia   = din;
   assign ena   = push_ok;
   assign wea   = push_ok;
   assign rsta  = 1'b0;
   assign addrb = rd_ptr;
   assign dib   = 4'b0000;
   assign enb   = pop_ok;
   assign web   = 1'b0;
   assign rstb  = 1'b0;
   assign dout  = dob;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 11'd1;
         if (pop_ok)  rd_ptr <= rd_ptr + 10'd1;
         count      <= count + {11'b0, push_ok} - {10'b0, pop_ok, 1'b0};
         dout_valid <= pop_ok;
         if (wr_en & full)  overflow  <= 1'b1;
         if (rd_en & empty) underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ramb4_s2_s4_fifo_ctrl.sv
// Bench for ramb4_s2_s4_fifo_ctrl with a behavioural RAMB4_S2_S4 and a
// scoreboard of expected popped words checked by an independent monitor.
module tb_ramb4_s2_s4_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [1:0]  din = 2'b00;
   logic        rd_en = 1'b0;
   logic [3:0]  dout;
   logic        dout_valid, full, empty, almost_full, almost_empty;
   logic [11:0] count;
   logic        overflow, underflow;
   logic [10:0] addra;
   logic [1:0]  dia;
   logic        ena, wea, rsta;
   logic [9:0]  addrb;
   logic [3:0]  dib;
   logic        enb, web, rstb;
   logic [3:0]  dob;

   int checks = 0;
   int errors = 0;

   ramb4_s2_s4_fifo_ctrl dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
      .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow),
      .addra(addra), .dia(dia), .ena(ena), .wea(wea), .rsta(rsta),
      .addrb(addrb), .dib(dib), .enb(enb), .web(web), .rstb(rstb),
      .dob(dob)
   );

   always #5 clk = ~clk;

   // behavioural block RAM: 2048x2 on port A aliased as 1024x4 on port B
   logic [1:0] mem [0:2047];
   always @(posedge clk) begin
      if (ena && wea) mem[addra] <= dia;
      if (enb) dob <= {mem[{addrb, 1'b1}], mem[{addrb, 1'b0}]};
   end

   // bench-side model
   int          mcount;
   logic [10:0] mwr;
   logic [9:0]  mrd;
   logic        movf, mudf, mvalid;
   logic [1:0]  units[$];
   logic [3:0]  sb[$];

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      mcount = 0; mwr = '0; mrd = '0;
      movf = 1'b0; mudf = 1'b0; mvalid = 1'b0;
      units.delete();
      sb.delete();
   endtask

   task automatic check_state();
      chk("count",        count,        12'(mcount));
      chk("empty",        empty,        12'(mcount < 2));
      chk("full",         full,         12'(mcount == 2048));
      chk("almost_full",  almost_full,  12'(mcount >= 1920));
      chk("almost_empty", almost_empty, 12'(mcount <= 4));
      chk("overflow",     overflow,     12'(movf));
      chk("underflow",    underflow,    12'(mudf));
      chk("dout_valid",   dout_valid,   12'(mvalid));
   endtask

   // One cycle: check registered state, drive requests, check RAM-side
   // combinational outputs, then advance the model. hset selects a
   // hand-computed expected word instead of the model's packing.
   task automatic tick(input logic we, input logic [1:0] d, input logic re,
                       input logic [3:0] hexp, input bit hset);
      logic push_ok, pop_ok;
      logic [1:0] u0, u1;
      @(negedge clk);
      check_state();
      wr_en = we; din = d; rd_en = re;
      push_ok = we && (mcount < 2048);
      pop_ok  = re && (mcount >= 2);
      #1;
      chk("ena",   ena,   12'(push_ok));
      chk("wea",   wea,   12'(push_ok));
      chk("enb",   enb,   12'(pop_ok));
      chk("addra", addra, 12'(mwr));
      chk("addrb", addrb, 12'(mrd));
      chk("dia",   dia,   12'(d));
      chk("static_b", {web, rsta, rstb, dib}, 12'd0);
      if (pop_ok) begin
         u0 = units.pop_front();
         u1 = units.pop_front();
         sb.push_back(hset ? hexp : {u1, u0});
         mrd = mrd + 10'd1;
      end
      if (push_ok) begin
         units.push_back(d);
         mwr = mwr + 11'd1;
      end
      if (we && !push_ok) movf = 1'b1;
      if (re && !pop_ok)  mudf = 1'b1;
      mcount = mcount + int'(push_ok) - 2 * int'(pop_ok);
      mvalid = pop_ok;
   endtask

   task automatic idle();
      tick(1'b0, 2'b00, 1'b0, 4'h0, 1'b0);
   endtask

   task automatic push(input logic [1:0] d);
      tick(1'b1, d, 1'b0, 4'h0, 1'b0);
   endtask

   // Reset asserted shortly after an active edge, with both requests high.
   task automatic async_reset();
      @(posedge clk);
      #2;
      rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
      #1;
      model_clear();
      chk("rst_dout_valid", dout_valid, 12'd0);
      chk("rst_ena",        ena,        12'd0);
      chk("rst_enb",        enb,        12'd0);
      chk("rst_addra",      addra,      12'd0);
      chk("rst_addrb",      addrb,      12'd0);
      check_state();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
   endtask

   function automatic logic [1:0] pat(input int i);
      return 2'(i ^ (i >> 2) ^ (i >> 5));
   endfunction

   // monitor: every presented word must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && dout_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dout: got %0h with no pop outstanding at %0t", dout, $time);
         end else begin
            chk("dout", 12'(dout), 12'(sb.pop_front()));
         end
      end
   end

   initial begin
      model_clear();
      async_reset();

      // basic packing
      push(2'b01);
      push(2'b10);
      tick(1'b0, 2'b00, 1'b1, 4'b1001, 1'b1);
      idle();

      // lone unit cannot be popped
      push(2'b11);
      tick(1'b0, 2'b00, 1'b1, 4'h0, 1'b0);
      idle();
      idle();

      // fill to full, then overflow
      async_reset();
      for (int i = 0; i < 2048; i++) push(pat(i));
      push(2'b11);
      idle();

      // drain in order, pointers wrap back to 0
      for (int j = 0; j < 1024; j++) tick(1'b0, 2'b00, 1'b1, 4'h0, 1'b0);
      idle();
      idle();

      // simultaneous push and pop at count 3
      push(2'b01);
      push(2'b11);
      push(2'b10);
      tick(1'b1, 2'b00, 1'b1, 4'b1101, 1'b1);
      tick(1'b0, 2'b00, 1'b1, 4'b0010, 1'b1);
      idle();

      // reset during streaming at count 100, then resume
      for (int i = 0; i < 102; i++) push(pat(i + 7));
      tick(1'b1, 2'b01, 1'b1, 4'h0, 1'b0);
      tick(1'b1, 2'b10, 1'b1, 4'h0, 1'b0);
      async_reset();
      push(2'b11);
      push(2'b00);
      tick(1'b0, 2'b00, 1'b1, 4'b0011, 1'b1);
      idle();
      idle();

      chk("sb_drained", 12'(sb.size()), 12'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
